// File: rtl/core_wb_arbiter.sv
// rtl/core_wb_arbiter.sv - round-robin writeback arbiter onto three register-file write ports
module core_wb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int REG_W   = 5,
  parameter int DATA_W  = 32,
  localparam int PTR_W  = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             stall,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0][REG_W-1:0]    req_rd,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_value,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [REG_W-1:0]                 wr_r_a,
  output logic [REG_W-1:0]                 wr_r_b,
  output logic [REG_W-1:0]                 wr_r_c,
  output logic                             wr_enable_a,
  output logic                             wr_enable_b,
  output logic                             wr_enable_c,
  output logic [DATA_W-1:0]                wr_value_a,
  output logic [DATA_W-1:0]                wr_value_b,
  output logic [DATA_W-1:0]                wr_value_c,
  output logic [PTR_W-1:0]                 rr_ptr_o
);

  // Requester count in the scan-sum width, so the modulo wrap compares like widths.
  localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W:0] ONE_W     = (PTR_W+1)'(1);

  logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]        ready_d;
  logic [2:0]                port_v;
  logic [2:0][REG_W-1:0]     port_rd;
  logic [2:0][DATA_W-1:0]    port_val;
  logic [1:0]                n_ports;
  logic                      any_ready;
  logic [PTR_W-1:0]          last_idx;

  logic [2:0]                en_q;
  logic [2:0][REG_W-1:0]     rd_q;
  logic [2:0][DATA_W-1:0]    val_q;

  // Round-robin grant scan: R0 writes are acked for free, duplicate destinations wait,
  // the rest fill ports a, b, c in scan order until all three are taken.
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic             conflict;
    ready_d   = '0;
    port_v    = '0;
    port_rd   = '0;
    port_val  = '0;
    n_ports   = 2'd0;
    any_ready = 1'b0;
    last_idx  = '0;
    sum       = '0;
    idx       = '0;
    conflict  = 1'b0;
    if (rst_n && !stall) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
        if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
        idx = sum[PTR_W-1:0];
        conflict = 1'b0;
        for (int p = 0; p < 3; p++) begin
          if (2'(p) < n_ports && port_rd[p] == req_rd[idx]) conflict = 1'b1;
        end
        if (req_valid[idx] && n_ports != 2'd3) begin
          if (req_rd[idx] == '0) begin
            ready_d[idx] = 1'b1;
            any_ready    = 1'b1;
            last_idx     = idx;
          end else if (!conflict) begin
            ready_d[idx]      = 1'b1;
            any_ready         = 1'b1;
            last_idx          = idx;
            port_v[n_ports]   = 1'b1;
            port_rd[n_ports]  = req_rd[idx];
            port_val[n_ports] = req_value[idx];
            n_ports           = n_ports + 2'd1;
          end
        end
      end
    end
  end

  // Next scan starts just past the last requester that was acknowledged.
  always_comb begin
    logic [PTR_W:0] inc;
    inc      = {1'b0, last_idx} + ONE_W;
    rr_ptr_d = rr_ptr_q;
    if (any_ready) rr_ptr_d = (inc == NUM_REQ_W) ? '0 : inc[PTR_W-1:0];
  end

  // Output stage and pointer; idle ports drop enable but keep their last address/data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      en_q     <= '0;
      rd_q     <= '0;
      val_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      en_q     <= port_v;
      for (int p = 0; p < 3; p++) begin
        if (port_v[p]) begin
          rd_q[p]  <= port_rd[p];
          val_q[p] <= port_val[p];
        end
      end
    end
  end

  assign req_ready   = ready_d;
  assign rr_ptr_o    = rr_ptr_q;
  assign wr_enable_a = en_q[0];
  assign wr_enable_b = en_q[1];
  assign wr_enable_c = en_q[2];
  assign wr_r_a      = rd_q[0];
  assign wr_r_b      = rd_q[1];
  assign wr_r_c      = rd_q[2];
  assign wr_value_a  = val_q[0];
  assign wr_value_b  = val_q[1];
  assign wr_value_c  = val_q[2];

endmodule

// File: tb/tb_core_wb_arbiter.sv
// tb/tb_core_wb_arbiter.sv - directed and randomized checks of core_wb_arbiter against a queue model
module tb_core_wb_arbiter;

  localparam int N = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  stall = 1'b0;
  logic [N-1:0]          req_valid = '0;
  logic [N-1:0][4:0]     req_rd = '0;
  logic [N-1:0][31:0]    req_value = '0;
  logic [N-1:0]          req_ready;
  logic [4:0]            wr_r_a, wr_r_b, wr_r_c;
  logic                  wr_enable_a, wr_enable_b, wr_enable_c;
  logic [31:0]           wr_value_a, wr_value_b, wr_value_c;
  logic [1:0]            rr_ptr_o;

  int tests = 0;
  int fails = 0;

  logic [N-1:0] exp_ready;
  logic [4:0]   g_rd[$];
  logic [31:0]  g_val[$];
  int           nxt_rr;
  int           m_rr;
  logic         m_en[3];
  logic [4:0]   m_rd[3];
  logic [31:0]  m_val[3];

  core_wb_arbiter #(.NUM_REQ(N), .REG_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .req_valid(req_valid), .req_rd(req_rd), .req_value(req_value),
    .req_ready(req_ready),
    .wr_r_a(wr_r_a), .wr_r_b(wr_r_b), .wr_r_c(wr_r_c),
    .wr_enable_a(wr_enable_a), .wr_enable_b(wr_enable_b), .wr_enable_c(wr_enable_c),
    .wr_value_a(wr_value_a), .wr_value_b(wr_value_b), .wr_value_c(wr_value_c),
    .rr_ptr_o(rr_ptr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 3; p++) begin
      m_en[p]  = 1'b0;
      m_rd[p]  = '0;
      m_val[p] = '0;
    end
    m_rr = 0;
  endtask

  // Spec rules: visit from rr_ptr, R0 acked without a port, duplicate rd deferred, at most 3 ports.
  task automatic model_eval();
    exp_ready = '0;
    g_rd.delete();
    g_val.delete();
    nxt_rr = m_rr;
    if (!stall && rst_n) begin
      for (int k = 0; k < N; k++) begin
        int i;
        bit dup;
        i = (m_rr + k) % N;
        dup = 1'b0;
        foreach (g_rd[j]) if (g_rd[j] == req_rd[i]) dup = 1'b1;
        if (req_valid[i] && g_rd.size() < 3 && (req_rd[i] == 5'd0 || !dup)) begin
          exp_ready[i] = 1'b1;
          nxt_rr = (i + 1) % N;
          if (req_rd[i] != 5'd0) begin
            g_rd.push_back(req_rd[i]);
            g_val.push_back(req_value[i]);
          end
        end
      end
    end
  endtask

  task automatic model_commit();
    for (int p = 0; p < 3; p++) begin
      m_en[p] = (p < g_rd.size());
      if (m_en[p]) begin
        m_rd[p]  = g_rd[p];
        m_val[p] = g_val[p];
      end
    end
    m_rr = nxt_rr;
  endtask

  // One clock: check at negedge against the model, advance the model at the posedge.
  task automatic cycle(input string tag);
    logic dup_obs, r0_obs;
    @(negedge clk);
    model_eval();
    chk({tag, "/ready"}, 32'(req_ready), 32'(exp_ready));
    chk({tag, "/rr"}, 32'(rr_ptr_o), 32'(m_rr));
    chk({tag, "/en_a"}, 32'(wr_enable_a), 32'(m_en[0]));
    chk({tag, "/en_b"}, 32'(wr_enable_b), 32'(m_en[1]));
    chk({tag, "/en_c"}, 32'(wr_enable_c), 32'(m_en[2]));
    chk({tag, "/r_a"}, 32'(wr_r_a), 32'(m_rd[0]));
    chk({tag, "/r_b"}, 32'(wr_r_b), 32'(m_rd[1]));
    chk({tag, "/r_c"}, 32'(wr_r_c), 32'(m_rd[2]));
    chk({tag, "/val_a"}, wr_value_a, m_val[0]);
    chk({tag, "/val_b"}, wr_value_b, m_val[1]);
    chk({tag, "/val_c"}, wr_value_c, m_val[2]);
    dup_obs = (wr_enable_a && wr_enable_b && wr_r_a == wr_r_b) ||
              (wr_enable_a && wr_enable_c && wr_r_a == wr_r_c) ||
              (wr_enable_b && wr_enable_c && wr_r_b == wr_r_c);
    r0_obs  = (wr_enable_a && wr_r_a == 5'd0) || (wr_enable_b && wr_r_b == 5'd0) ||
              (wr_enable_c && wr_r_c == 5'd0);
    chk({tag, "/inv_dup"}, 32'(dup_obs), 32'd0);
    chk({tag, "/inv_r0"}, 32'(r0_obs), 32'd0);
    @(posedge clk);
    #1;
    model_commit();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic refresh(input int i);
    req_valid[i] = ($urandom_range(0, 3) != 0);
    req_rd[i]    = 5'($urandom_range(0, 7));
    req_value[i] = $urandom;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle("reset_state");

    // Single write from requester 2
    req_valid = 4'b0100;
    req_rd[2] = 5'd5;
    req_value[2] = 32'hDEADBEEF;
    cycle("single");
    req_valid = '0;
    chk("single/port_a_en", 32'(wr_enable_a), 32'd1);
    chk("single/port_a_rd", 32'(wr_r_a), 32'd5);
    chk("single/port_a_val", wr_value_a, 32'hDEADBEEF);
    chk("single/rr", 32'(rr_ptr_o), 32'd3);

    // Reset while port a is enabled; requester 1 keeps its request across reset
    req_valid = 4'b0010;
    req_rd[1] = 5'd6;
    req_value[1] = 32'h0000_1234;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst/en_a", 32'(wr_enable_a), 32'd0);
    chk("midrst/en_any", 32'(wr_enable_b | wr_enable_c), 32'd0);
    chk("midrst/rr", 32'(rr_ptr_o), 32'd0);
    @(negedge clk);
    chk("midrst/ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle("post_reset_serve");
    req_valid = '0;
    cycle("post_reset_drain");

    // Four-way contention from rr_ptr = 0
    do_reset();
    req_valid = 4'hF;
    for (int i = 0; i < N; i++) begin
      req_rd[i] = 5'(i + 1);
      req_value[i] = 32'hA000_0000 + 32'(i);
    end
    cycle("four_c1");
    chk("four_c1/rr", 32'(rr_ptr_o), 32'd3);
    chk("four_c1/rd_c", 32'(wr_r_c), 32'd3);
    req_valid = 4'b1000;
    cycle("four_c2");
    chk("four_c2/rd_a", 32'(wr_r_a), 32'd4);
    req_valid = '0;
    cycle("four_drain");

    // Same destination on two requesters
    do_reset();
    req_valid = 4'b0011;
    req_rd[0] = 5'd7;
    req_rd[1] = 5'd7;
    req_value[0] = 32'h1111_1111;
    req_value[1] = 32'h2222_2222;
    cycle("samerd_c1");
    req_valid = 4'b0010;
    cycle("samerd_c2");
    chk("samerd_c2/val_a", wr_value_a, 32'h2222_2222);
    req_valid = '0;
    cycle("samerd_drain");

    // R0 discard does not consume a port
    do_reset();
    req_valid = 4'hF;
    req_rd[0] = 5'd0;
    req_rd[1] = 5'd8;
    req_rd[2] = 5'd9;
    req_rd[3] = 5'd10;
    cycle("r0_c1");
    chk("r0/rd_a", 32'(wr_r_a), 32'd8);
    chk("r0/rd_c", 32'(wr_r_c), 32'd10);
    req_valid = '0;
    cycle("r0_drain");

    // Stall for two cycles, then release
    req_valid = 4'hF;
    for (int i = 0; i < N; i++) req_rd[i] = 5'(i + 11);
    stall = 1'b1;
    cycle("stall_1");
    cycle("stall_2");
    stall = 1'b0;
    cycle("stall_release");
    req_valid = '0;
    cycle("stall_drain");

    // Randomized traffic: requesters hold until acknowledged
    for (int i = 0; i < N; i++) refresh(i);
    for (int c = 0; c < 400; c++) begin
      stall = ($urandom_range(0, 7) == 0);
      cycle("rand");
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || exp_ready[i]) refresh(i);
      end
    end
    stall = 1'b0;
    req_valid = '0;
    cycle("final_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/core_wb_arbiter.md
Name: core_wb_arbiter

Overview:
- Shares the three register-file write ports (a, b, c) among NUM_REQ writeback requesters, e.g. ALU, multiplier, load/store and branch-link units.
- Each requester uses a valid/ready handshake. Up to three requests are granted per cycle with round-robin fairness.
- Granted writes are registered and driven onto the register file's wr_r_x / wr_enable_x / wr_value_x inputs.
- Sits between the execute/memory units and core_regs. It also guarantees the register file never sees two enabled ports to the same register in one cycle.

Parameters:
- NUM_REQ, 4, number of writeback requesters (2..8).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  when 1: grant nothing this cycle; output enables go 0 next cycle.
- req_valid  in  NUM_REQ  requester i has a write pending.
- req_rd  in  NUM_REQ x reg_num  destination register of requester i.
- req_value  in  NUM_REQ x word  data of requester i.
- req_ready  out  NUM_REQ  combinational; the write of requester i is accepted this cycle.
- wr_r_a, wr_r_b, wr_r_c  out  reg_num  registered destination per port.
- wr_enable_a, wr_enable_b, wr_enable_c  out  1  registered write enable per port.
- wr_value_a, wr_value_b, wr_value_c  out  word  registered data per port.
- rr_ptr_o  out  $clog2(NUM_REQ)  current round-robin start index (debug/verification).

Behaviour:
- Reset (async, rst_n low):
  - All wr_enable_x = 0; wr_r_x = R0; wr_value_x = 0; rr_ptr = 0.
  - req_ready = 0 while rst_n is low.
  - Reset mid-operation drops any registered write; a requester still holding valid is served after reset.
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - While req_valid[i] && !req_ready[i], requester i holds req_rd and req_value stable.
  - req_ready does not depend on req_value.
- Grant scan (combinational, each cycle stall == 0):
  - Visit requesters in order rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Valid request with req_rd == R0: ready = 1 and consumes no port (write discarded).
  - Valid request whose req_rd equals a destination already granted a port this cycle: ready = 0 (deferred to a later cycle).
  - Otherwise, if a port is free: ready = 1. Ports are assigned in scan order: first grant to a, second to b, third to c.
  - After three port grants, remaining requesters get ready = 0, including R0 requests still scanned after port exhaustion.
- Output stage (posedge clk):
  - Each port's wr_r_x / wr_value_x / wr_enable_x take the grant assigned to it. Unused ports get wr_enable_x = 0; wr_r_x / wr_value_x hold their previous value.
  - Latency: handshake in cycle N; port enabled during cycle N+1; core_regs commits the data at the edge ending N+1.
- Round-robin pointer:
  - After a cycle with at least one ready (including R0 discards), rr_ptr = (index of last ready requester + 1) mod NUM_REQ.
  - No grants: rr_ptr unchanged.
  - stall == 1: all ready = 0, all enables 0 next cycle, rr_ptr frozen.
- Invariants:
  - Never two enabled ports with equal wr_r_x in the same cycle.
  - Never wr_enable_x = 1 with wr_r_x = R0.
  - A continuously valid requester is granted within ceil(NUM_REQ/3) + 1 cycles, absent stall and same-rd conflicts.
- Ordering: no write ordering is guaranteed between different requesters. Issue logic must not place two in-flight writes to the same register on different requesters.

Test Plan:
- Reset: assert rst_n=0 mid-stream with wr_enable_a=1 -> all enables 0 and rr_ptr_o=0 immediately; ready=0 while rst_n low.
- Single write: req 2 valid, rd=5, value=0xDEADBEEF -> req_ready=4'b0100 that cycle; next cycle wr_enable_a=1, wr_r_a=5, wr_value_a=0xDEADBEEF, b/c disabled; rr_ptr_o=3.
- Four-way contention, rr_ptr=0, all valid, distinct rd 1..4:
  - cycle 1: ready=4'b0111, ports a/b/c = rd 1/2/3, rr_ptr=3;
  - cycle 2: ready=4'b1000, port a = rd 4.
- Same-rd conflict: req0 and req1 both rd=7, rr_ptr=0 -> only req0 ready; req1 granted next cycle on port a.
- R0 discard: req0 rd=R0, req1..3 valid rd 8,9,10 -> all four ready same cycle; ports a/b/c = 8/9/10; no enable targets R0.
- Stall: all valid with stall=1 for 2 cycles -> ready=0, enables 0, rr_ptr unchanged; after release, resumes from the same rr_ptr.
